// File: rtl/dec2ascii_arb_pkg.sv
// Shared types and widths for the dec2ascii arbiter slice.
package dec2ascii_arb_pkg;

  localparam int DEC_W   = 32;
  localparam int ASCII_W = 512;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dec2ascii_arbiter_if.sv
// Requester and converter signals of the dec2ascii arbiter.
// The slave modport is the arbiter; the master modport is the side that
// drives the requests and hosts the converter.
interface dec2ascii_arbiter_if #(
  parameter int NREQ = 4
) ();
  import dec2ascii_arb_pkg::*;

  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*DEC_W-1:0] value;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [ASCII_W-1:0]    result_ascii;
  logic [ID_W-1:0]       result_id;
  logic                  busy;
  logic                  err;
  logic [DEC_W-1:0]      conv_decimal;
  logic                  conv_load_data;
  logic                  conv_complete;
  logic [ASCII_W-1:0]    conv_ascii;

  modport slave (
    input  req, value, conv_complete, conv_ascii,
    output grant, done, result_ascii, result_id, busy, err,
           conv_decimal, conv_load_data
  );

  modport master (
    output req, value, conv_complete, conv_ascii,
    input  grant, done, result_ascii, result_id, busy, err,
           conv_decimal, conv_load_data
  );

endinterface

// File: rtl/dec2ascii_arbiter_rr_arbiter.sv
// Round-robin pick: the first set req bit searching upward from ptr,
// wrapping from NREQ-1 to 0. Purely combinational.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] pick,
  output logic [ID_W-1:0] pick_idx,
  output logic            pick_valid
);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = ID_W'(idx);
      end
    end
    pick = pick_valid ? (NREQ'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/dec2ascii_arbiter.sv
// Shares one decimal_to_ascii converter among NREQ requesters.
// Optional build macro DEC2ASCII_ARB_TIMEOUT_EN: abandons a conversion
// after TIMEOUT cycles in WAIT and pulses err; without it err is 0 and
// WAIT waits indefinitely.
module dec2ascii_arbiter
  import dec2ascii_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int LOAD_CYCLES = 10,
  parameter int TIMEOUT     = 255
) (
  input logic             clock,
  input logic             reset,
  dec2ascii_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(max_int(LOAD_CYCLES, TIMEOUT) + 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   cur_id_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [NREQ-1:0]   pick;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_valid;
  logic              load_last;
  logic              wait_timeout;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (bus.req),
    .ptr        (ptr_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // One counter serves both LOAD and WAIT; it is cleared on entry to each.
  assign load_last = (cnt_q == CNT_W'(LOAD_CYCLES - 1));

`ifdef DEC2ASCII_ARB_TIMEOUT_EN
  logic err_q;
  assign wait_timeout = (state_q == ST_WAIT) && !bus.conv_complete &&
                        (cnt_q == CNT_W'(TIMEOUT - 1));
  assign bus.err      = err_q;
`else
  assign wait_timeout = 1'b0;
  assign bus.err      = 1'b0;
`endif

  assign bus.busy = (state_q != ST_IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_LOAD;
      ST_LOAD: if (load_last)  state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.conv_complete) state_d = ST_DONE;
        else if (wait_timeout) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, load strobe, pulses, result registers.
  // NOTE: the 512-bit result is a plain register, not a memory, so it is
  // cleared by reset along with everything else.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.conv_decimal   <= '0;
      bus.conv_load_data <= 1'b0;
      bus.grant          <= '0;
      bus.done           <= '0;
      bus.result_ascii   <= '0;
      bus.result_id      <= '0;
      cur_id_q           <= '0;
      cnt_q              <= '0;
      ptr_q              <= '0;
`ifdef DEC2ASCII_ARB_TIMEOUT_EN
      err_q              <= 1'b0;
`endif
    end else begin
      bus.grant <= '0;
      bus.done  <= '0;
`ifdef DEC2ASCII_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            bus.conv_decimal   <= bus.value[pick_idx*DEC_W +: DEC_W];
            bus.conv_load_data <= 1'b1;
            bus.grant          <= pick;
            cur_id_q           <= pick_idx;
            cnt_q              <= '0;
            // Pointer moves past the winner at grant time, so a timeout
            // needs no further pointer update.
            ptr_q              <= (pick_idx == ID_W'(NREQ - 1)) ? '0
                                                                : pick_idx + 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_last) begin
            bus.conv_load_data <= 1'b0;
            cnt_q              <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.conv_complete) begin
            bus.result_ascii <= bus.conv_ascii;
            bus.result_id    <= cur_id_q;
            bus.done         <= NREQ'(1) << cur_id_q;
          end
`ifdef DEC2ASCII_ARB_TIMEOUT_EN
          else if (wait_timeout) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ST_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dec2ascii_arbiter.md
DEC2ASCII_ARBITER -- requirements
Module: dec2ascii_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one decimal_to_ascii converter.
REQ-002 Parameter LOAD_CYCLES, default 10: number of cycles conv_load_data is held high per conversion.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles spent in WAIT; used only when the macro in REQ-024 is defined.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  NREQ  level request, one bit per requester.
REQ-007 value  in  NREQ*32  requester i's operand is value[32*i+31:32*i].
REQ-008 grant  out  NREQ  one-hot, one-cycle pulse acknowledging the accepted request.
REQ-009 done  out  NREQ  one-hot, one-cycle pulse marking the result valid for that requester.
REQ-010 result_ascii  out  512  converted string, registered.
REQ-011 result_id  out  $clog2(NREQ)  index of the requester that owns result_ascii.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 err  out  1  one-cycle pulse on timeout.
REQ-014 conv_decimal  out  32  operand to the converter.
REQ-015 conv_load_data  out  1  load strobe to the converter.
REQ-016 conv_complete  in  1  converter contract: low while load is high; goes high when conv_ascii is valid.
REQ-017 conv_ascii  in  512  converter output.

Function
REQ-018 The arbiter SHALL implement the states IDLE, LOAD, WAIT and DONE.
REQ-019 IDLE with any req bit set: on the next edge, enter LOAD and select sel by round-robin. Register conv_decimal=value[sel], set conv_load_data=1, pulse grant[sel] for one cycle, latch cur_id=sel, clear the cycle counter.
REQ-020 LOAD: conv_load_data SHALL be high for exactly LOAD_CYCLES consecutive cycles. When the counter reaches LOAD_CYCLES-1, clear load and enter WAIT.
REQ-021 WAIT with conv_complete=1: on the next edge, register result_ascii=conv_ascii and result_id=cur_id, pulse done[cur_id] for one cycle, enter DONE.
REQ-022 DONE: return to IDLE on the next edge. Minimum spacing between consecutive grants is LOAD_CYCLES+3 cycles.
REQ-023 Round-robin rule:
- Search order starts at the index after the last granted requester, wrapping from NREQ-1 to 0.
- After reset, index 0 has highest priority.
- A requester that holds req continuously cannot be granted twice while another req is pending.
- operand is sampled only at grant; req and value may change afterwards without effect.
- req bits arriving while busy are held off until IDLE; they are not lost if still asserted.
- result_ascii holds its value until the next done.

Configuration
REQ-024 Macro DEC2ASCII_ARB_TIMEOUT_EN defined: a WAIT counter SHALL run. After TIMEOUT cycles in WAIT without conv_complete, pulse err for one cycle, suppress done, leave result_ascii unchanged, advance the round-robin pointer and return to IDLE.
REQ-025 Macro DEC2ASCII_ARB_TIMEOUT_EN not defined: err SHALL be tied 0 and WAIT SHALL wait indefinitely.

Reset
REQ-026 Asserting reset SHALL immediately force these values, including mid-LOAD or mid-WAIT:
- state=IDLE, conv_load_data=0, conv_decimal=0
- grant=0, done=0, err=0, busy=0
- result_ascii=0, result_id=0
- counters=0, round-robin pointer=0
REQ-027 After reset deassertion, the first grant SHALL occur no earlier than one edge after a req bit is sampled high.

Structure
REQ-028 Package dec2ascii_arb_pkg SHALL hold:
- the state enum
- DEC_W=32
- ASCII_W=512
REQ-029 The round-robin selection SHALL be one sub-module, rr_arbiter (inputs req and pointer; outputs a one-hot pick and its index).

Verification
REQ-030 Single request: req[0]=1, value0=32'd12812 → grant[0] pulse; load high for 10 cycles; with a converter model, done[0] pulses, result_ascii contains "12812" and result_id=0.
REQ-031 Maximum operand: value=32'hFFFF_FFFF → result_ascii contains "4294967295".
REQ-032 Contention: req=4'b1111 held, values 128, 12, 7, 0 → grants in order 0,1,2,3,0; results "128", "12", "7", "0" paired with the correct result_id.
REQ-033 Reset mid-LOAD: reset asserted in load cycle 5 → conv_load_data=0 and busy=0 without waiting for a clock edge. After release, req[2] is granted first, since pointer=0 and only req[2] is set.
REQ-034 Timeout, macro defined with TIMEOUT=20: conv_complete stuck at 0 → err pulses exactly 20 cycles after WAIT entry, no done, next pending req granted. Macro undefined: busy stays high.
REQ-035 Late request: req[3] raised during WAIT of requester 1 → grant[3] asserted exactly 2 cycles after done[1].
